// File: rtl/onehot_encoder_stream_if.sv
// Stream bundle for the one-hot encoder: a code channel in and an index/error channel out.
// The slave modport is the encoder's view; the master modport is the producer/consumer side.
interface onehot_encoder_stream_if #(
  parameter int N = 4,
  parameter int W = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_code;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_index;
  logic         out_err;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_index, out_err
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_index, out_err
  );
endinterface

// File: rtl/onehot_encoder_stream.sv
// Streaming one-hot to binary encoder with one registered output stage,
// illegal-code flagging and saturating transfer/error counters.
module onehot_encoder_stream #(
  parameter int N     = 4,
  parameter int W     = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_encoder_stream_if.slave s,
  input  logic                  clear_cnt,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      xfer_count
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("onehot_encoder_stream: N must be in 2..32");
  end

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_index_q, out_index_d;
  logic             out_err_q,   out_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

  logic             accept;
  logic             transfer;
  logic [W-1:0]     enc_idx;
  logic             enc_err;
  logic [CNT_W-1:0] err_base;
  logic [CNT_W-1:0] xfer_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign s.in_ready = !out_valid_q || s.out_ready;
  assign accept     = s.in_valid && s.in_ready;
  assign transfer   = out_valid_q && s.out_ready;

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    enc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (s.in_code[i]) enc_idx = W'(i);
    end
    enc_err = (s.in_code == '0) || ((s.in_code & (s.in_code - ONE_N)) != '0);
  end

  // The old result may leave in the same cycle a new one is loaded.
  always_comb begin
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_index_d = enc_idx;
      out_err_d   = enc_err;
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear takes effect first, so an accept in the same cycle counts from zero.
  always_comb begin
    xfer_base    = clear_cnt ? '0 : xfer_count_q;
    err_base     = clear_cnt ? '0 : err_count_q;
    xfer_count_d = accept ? sat_inc(xfer_base) : xfer_base;
    err_count_d  = (accept && enc_err) ? sat_inc(err_base) : err_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_err_q    <= 1'b0;
      err_count_q  <= '0;
      xfer_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_err_q    <= out_err_d;
      err_count_q  <= err_count_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_index = out_index_q;
  assign s.out_err   = out_err_q;
  assign err_count   = err_count_q;
  assign xfer_count  = xfer_count_q;

endmodule

// File: tb/tb_onehot_encoder_stream.sv
// Directed checks on an N=4/CNT_W=3 encoder plus a scoreboarded random soak on N=8.
module tb_onehot_encoder_stream;

  logic clk = 1'b0;
  logic rst;
  logic clear_a, clear_b;
  logic [2:0] err_a, xfer_a;
  logic [7:0] err_b, xfer_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  onehot_encoder_stream_if #(.N(4)) bus_a ();
  onehot_encoder_stream_if #(.N(8)) bus_b ();

  onehot_encoder_stream #(.N(4), .CNT_W(3)) dut_a (
    .clk(clk), .rst(rst), .s(bus_a.slave),
    .clear_cnt(clear_a), .err_count(err_a), .xfer_count(xfer_a)
  );

  onehot_encoder_stream #(.N(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .s(bus_b.slave),
    .clear_cnt(clear_b), .err_count(err_b), .xfer_count(xfer_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors for dut_a: code, expected index, expected error.
  logic [3:0] ill_code [3] = '{4'b0000, 4'b0110, 4'b1111};
  int         ill_idx  [3] = '{0, 1, 0};

  // Soak model state.
  typedef struct packed { logic [2:0] idx; logic err; } res_t;
  res_t q_exp[$];
  logic m_valid;
  int   m_xfer, m_err;

  function automatic res_t model_enc(input logic [7:0] c);
    res_t r;
    r.idx = '0;
    r.err = ($countones(c) != 1);
    for (int i = 0; i < 8; i++) begin
      if (c[i]) begin
        r.idx = 3'(i);
        break;
      end
    end
    return r;
  endfunction

  initial begin
    bus_a.in_valid = 0; bus_a.in_code = '0; bus_a.out_ready = 1;
    bus_b.in_valid = 0; bus_b.in_code = '0; bus_b.out_ready = 1;
    clear_a = 0; clear_b = 0;

    // Reset and idle.
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1;
    check("rst_out_valid", bus_a.out_valid, 0);
    check("rst_out_index", bus_a.out_index, 0);
    check("rst_out_err",   bus_a.out_err, 0);
    check("rst_err_cnt",   err_a, 0);
    check("rst_xfer_cnt",  xfer_a, 0);
    check("rst_in_ready",  bus_a.in_ready, 1);

    // Legal sweep, back-to-back with out_ready held high.
    tick();
    for (int i = 0; i < 4; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_code  = 4'(1 << i);
      tick();
      check("sweep_valid", bus_a.out_valid, 1);
      check("sweep_index", bus_a.out_index, i);
      check("sweep_err",   bus_a.out_err, 0);
    end
    bus_a.in_valid = 0;
    tick();
    check("sweep_drained", bus_a.out_valid, 0);
    check("sweep_xfer",    xfer_a, 4);
    check("sweep_errcnt",  err_a, 0);

    // Idle X on in_code must not disturb anything.
    bus_a.in_code = 'x;
    repeat (2) tick();
    check("x_idle_valid", bus_a.out_valid, 0);
    check("x_idle_index", bus_a.out_index, 3);
    check("x_idle_xfer",  xfer_a, 4);

    // Clear with no accept.
    clear_a = 1;
    tick();
    clear_a = 0;
    check("clr_xfer", xfer_a, 0);
    check("clr_err",  err_a, 0);

    // Illegal codes.
    for (int i = 0; i < 3; i++) begin
      bus_a.in_valid = 1;
      bus_a.in_code  = ill_code[i];
      tick();
      check("ill_index", bus_a.out_index, ill_idx[i]);
      check("ill_err",   bus_a.out_err, 1);
    end
    bus_a.in_valid = 0;
    tick();
    check("ill_errcnt", err_a, 3);
    check("ill_xfer",   xfer_a, 3);

    // Backpressure.
    bus_a.out_ready = 0;
    bus_a.in_valid  = 1;
    bus_a.in_code   = 4'b0100;
    tick();
    check("bp_valid", bus_a.out_valid, 1);
    check("bp_index", bus_a.out_index, 2);
    check("bp_ready", bus_a.in_ready, 0);
    bus_a.in_code = 4'b1000;
    repeat (5) begin
      tick();
      check("bp_hold_index", bus_a.out_index, 2);
      check("bp_hold_ready", bus_a.in_ready, 0);
      check("bp_hold_xfer",  xfer_a, 4);
    end
    bus_a.out_ready = 1;
    #1;
    check("bp_ready_comb", bus_a.in_ready, 1);
    @(posedge clk); #1;
    check("bp_next_index", bus_a.out_index, 3);
    check("bp_next_valid", bus_a.out_valid, 1);
    check("bp_next_xfer",  xfer_a, 5);
    bus_a.in_valid = 0;
    tick();
    check("bp_drained", bus_a.out_valid, 0);

    // Counter saturation at 7 with CNT_W=3.
    clear_a = 1;
    tick();
    clear_a = 0;
    bus_a.in_valid = 1;
    bus_a.in_code  = 4'b0000;
    repeat (9) tick();
    check("sat_err",  err_a, 7);
    check("sat_xfer", xfer_a, 7);
    clear_a = 1;
    tick();
    check("clr_acc_ill_err",  err_a, 1);
    check("clr_acc_ill_xfer", xfer_a, 1);
    bus_a.in_code = 4'b0010;
    tick();
    check("clr_acc_leg_err",  err_a, 0);
    check("clr_acc_leg_xfer", xfer_a, 1);
    clear_a = 0;
    bus_a.in_valid = 0;
    tick();

    // Mid-stream reset drops the held result without an edge.
    bus_a.out_ready = 0;
    bus_a.in_valid  = 1;
    bus_a.in_code   = 4'b0010;
    tick();
    bus_a.in_valid = 0;
    check("mid_pre_valid", bus_a.out_valid, 1);
    #2 rst = 1;
    #1;
    check("mid_rst_valid", bus_a.out_valid, 0);
    check("mid_rst_index", bus_a.out_index, 0);
    check("mid_rst_xfer",  xfer_a, 0);
    tick();
    rst = 0;
    bus_a.out_ready = 1;
    tick();

    // Random soak on the N=8 instance.
    m_valid = 0; m_xfer = 0; m_err = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic acc;
      res_t got;
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
      bus_b.in_code   = ($urandom_range(0, 1) != 0) ? 8'(1 << $urandom_range(0, 7))
                                                    : 8'($urandom);
      #1;
      acc = bus_b.in_valid && (!m_valid || bus_b.out_ready);
      check("soak_in_ready", bus_b.in_ready, !m_valid || bus_b.out_ready);
      check("soak_out_valid", bus_b.out_valid, m_valid);
      if (m_valid && bus_b.out_ready) begin
        got.idx = bus_b.out_index;
        got.err = bus_b.out_err;
        if (q_exp.size() == 0) check("soak_dup", 1, 0);
        else check("soak_result", got, q_exp.pop_front());
      end
      if (acc) begin
        q_exp.push_back(model_enc(bus_b.in_code));
        if (m_xfer < 255) m_xfer++;
        if (model_enc(bus_b.in_code).err && m_err < 255) m_err++;
      end
      m_valid = acc || (m_valid && !bus_b.out_ready);
      tick();
    end
    bus_b.in_valid  = 0;
    bus_b.out_ready = 1;
    tick();
    if (m_valid) begin
      void'(q_exp.pop_front());
      m_valid = 0;
    end
    tick();
    check("soak_final_valid", bus_b.out_valid, 0);
    check("soak_lost", q_exp.size(), 0);
    check("soak_xfer", xfer_b, m_xfer);
    check("soak_err",  err_b, m_err);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/onehot_encoder_stream.md
Name: onehot_encoder_stream

Overview:
- Streaming one-hot-to-binary encoder. It is the inverse of our decoder-based gate blocks.
- Accepts N-bit one-hot codes over a valid/ready handshake. Returns the binary index of the set bit through one registered output stage.
- Flags illegal codes (all-zero or multi-hot) and keeps saturating error and transfer counters for self-checking benches and downstream gate-level checkers.

Parameters:
- N, 4, width of the one-hot input code; legal range is 2 to 32.
- W, $clog2(N), width of the output index. Derived; do not override.
- CNT_W, 8, width of the err_count and xfer_count counters.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_code is presented.
- in_ready  output  1  block can accept in_code this cycle.
- in_code  input  N  one-hot code.
- out_valid  output  1  out_index and out_err hold a result.
- out_ready  input  1  downstream accepts the result.
- out_index  output  W  binary index of the set bit.
- out_err  output  1  accepted code was not exactly one-hot.
- clear_cnt  input  1  synchronous clear of both counters.
- err_count  output  CNT_W  number of illegal codes accepted; saturates.
- xfer_count  output  CNT_W  number of codes accepted; saturates.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_index=0, out_err=0, err_count=0, xfer_count=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Asserting rst mid-transfer drops any held result immediately; there is no partial output.
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - An output is transferred when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational from out_ready). Full throughput: one code per cycle when out_ready is held at 1.
- Latency: exactly 1 cycle. A code accepted at edge k appears with out_valid=1 after edge k.
- Output register update rules:
  - accept: load the new result and set out_valid=1. This applies even when the previous result is transferring in the same cycle.
  - transfer without accept: out_valid=0.
  - neither: hold out_valid, out_index and out_err unchanged.
- Stability: while out_valid=1 && out_ready=0, out_index and out_err must not change, and in_ready=0.
- Encoding:
  - popcount(in_code)==1: out_index = position of the set bit; out_err=0.
  - popcount==0: out_index=0; out_err=1.
  - popcount>=2: out_index = lowest set bit position; out_err=1.
- Counters:
  - On every accept, xfer_count increments, saturating at 2^CNT_W-1.
  - On accept of an illegal code, err_count also increments, with the same saturation.
- clear_cnt:
  - With no accept in the same cycle, both counters go to 0.
  - With an accept in the same cycle, the clear applies first and the accept is then counted: xfer_count=1, and err_count=1 if the code is illegal, else 0.
- in_code is ignored when in_valid=0. X on in_code while in_valid=0 must not propagate to the outputs or counters.
- No combinational path from in_code or in_valid to any output.

Test Plan:
- Reset and idle: assert rst for 3 cycles, then release. Outputs and counters are all 0, in_ready=1. Assert rst mid-stream while out_valid=1: out_valid drops to 0 without waiting for an edge.
- Legal sweep with N=4 and out_ready=1: stream 0001, 0010, 0100, 1000 back-to-back. out_index is 0,1,2,3 on consecutive cycles, each one cycle after accept. out_err=0 throughout, xfer_count=4, err_count=0.
- Illegal codes:
  - 0000 gives out_index=0, out_err=1.
  - 0110 gives out_index=1, out_err=1.
  - 1111 gives out_index=0, out_err=1.
  - After these, err_count=3 and xfer_count=3.
- Backpressure: present 0100 with out_ready=0. After the accept, out_valid=1 and in_ready=0. Hold out_ready=0 for 5 cycles while presenting 1000: out_index stays 2 and 1000 is not accepted. Raise out_ready: 2 transfers in the same cycle 1000 is accepted, and out_index=3 the next cycle.
- Counter edges with CNT_W=3: accept 9 illegal codes and both counters saturate at 7. Assert clear_cnt together with an accept of 0000: err_count=1, xfer_count=1 next cycle.
- Random soak with N=8: 10k cycles of random in_valid, out_ready and in_code. A scoreboard checks order, index, err flag, no loss or duplication, and final counters against the model.
